// File: rtl/lenet_pkg.sv
// Shared types and frame geometry for the LeNet-5 capture front end.
package lenet_pkg;

    localparam int IMG_DS_W               = 32;
    localparam int IMG_DS_H               = 32;
    localparam int PIX_PER_FRAME          = IMG_DS_W * IMG_DS_H;
    localparam int DEFAULT_GAP_CYCLES     = 100;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1048576;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BUF = 3'd1,
        CAPTURE  = 3'd2,
        GAP      = 3'd3,
        DONE     = 3'd4,
        ERR      = 3'd5
    } seq_state_t;

    // One-hot flag for a ping-pong bank index.
    function automatic logic [1:0] bank_mask(input logic bank);
        return bank ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/pingpong_bank_tracker.sv
// Ready flags for the two frame-buffer banks and the bank currently being written.
module pingpong_bank_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_ready,
    input  logic [1:0] rel,
    output logic [1:0] rd_ready,
    output logic       wr_bank
);
    import lenet_pkg::*;

    logic [1:0] rd_ready_r;
    logic       wr_bank_r;
    logic [1:0] set_mask_s;

    // Bank being completed this cycle; a same-cycle set overrides a release.
    always_comb begin
        set_mask_s = 2'b00;
        if (set_ready) begin
            set_mask_s = bank_mask(wr_bank_r);
        end else begin
            set_mask_s = 2'b00;
        end
    end

    // Ready flags and write-bank toggle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ready_r <= 2'b00;
            wr_bank_r  <= 1'b0;
        end else begin
            rd_ready_r <= (rd_ready_r & ~rel) | set_mask_s;
            if (set_ready) begin
                wr_bank_r <= ~wr_bank_r;
            end
        end
    end

    assign rd_ready = rd_ready_r;
    assign wr_bank  = wr_bank_r;

endmodule

// File: rtl/frame_sequencer.sv
// Capture sequencer: drives the sensor start level, writes pixels into the
// ping-pong buffer, enforces the inter-frame gap, frame limit and stall watchdog.
module frame_sequencer #(
    parameter int PIX_PER_FRAME  = lenet_pkg::PIX_PER_FRAME,
    parameter int ADDR_W         = 10,
    parameter int GAP_CYCLES     = lenet_pkg::DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = lenet_pkg::DEFAULT_TIMEOUT_CYCLES,
    parameter int FRAME_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_run,
    input  logic [FRAME_W-1:0] cfg_num_frames,
    input  logic               ds_valid,
    input  logic [7:0]         ds_data,
    output logic               sensor_start,
    output logic               buf_we,
    output logic [ADDR_W:0]    buf_addr,
    output logic [7:0]         buf_wdata,
    output logic [1:0]         rd_ready,
    input  logic [1:0]         rd_release,
    output logic               frame_done,
    output logic [FRAME_W-1:0] frame_idx,
    output logic               busy,
    output logic               timeout_err
);
    import lenet_pkg::*;

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t         state_r, state_nx_s;
    logic [ADDR_W-1:0]  pix_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [WD_W-1:0]    wd_cnt_r;
    logic               sensor_start_r, buf_we_r, frame_done_r, busy_r, timeout_err_r;
    logic [ADDR_W:0]    buf_addr_r;
    logic [7:0]         buf_wdata_r;
    logic [FRAME_W-1:0] frame_idx_r;

    logic               accept_s, frame_end_s, wd_expire_s, gap_end_s, limit_hit_s;
    logic [1:0]         rd_ready_s;
    logic               wr_bank_s;

    assign accept_s    = (state_r == CAPTURE) && ds_valid;
    assign frame_end_s = accept_s && (pix_cnt_r == ADDR_W'(PIX_PER_FRAME - 1));
    assign wd_expire_s = (state_r == CAPTURE) && !ds_valid && (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));
    assign gap_end_s   = (gap_cnt_r == GAP_W'(GAP_CYCLES - 1));
    assign limit_hit_s = (cfg_num_frames != {FRAME_W{1'b0}}) && (frame_idx_r == cfg_num_frames);

    pingpong_bank_tracker u_banks (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_ready (frame_end_s),
        .rel       (rd_release),
        .rd_ready  (rd_ready_s),
        .wr_bank   (wr_bank_s)
    );

    // Next-state selection; capture only starts into a bank the consumer has freed.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (cfg_run) begin
                    state_nx_s = rd_ready_s[wr_bank_s] ? WAIT_BUF : CAPTURE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT_BUF: begin
                if (!cfg_run) begin
                    state_nx_s = IDLE;
                end else if (!rd_ready_s[wr_bank_s]) begin
                    state_nx_s = CAPTURE;
                end else begin
                    state_nx_s = WAIT_BUF;
                end
            end
            CAPTURE: begin
                if (frame_end_s) begin
                    state_nx_s = GAP;
                end else if (wd_expire_s) begin
                    state_nx_s = ERR;
                end else begin
                    state_nx_s = CAPTURE;
                end
            end
            GAP: begin
                if (!gap_end_s) begin
                    state_nx_s = GAP;
                end else if (limit_hit_s) begin
                    state_nx_s = DONE;
                end else if (!cfg_run) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = rd_ready_s[wr_bank_s] ? WAIT_BUF : CAPTURE;
                end
            end
            DONE, ERR: begin
                if (!cfg_run) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            pix_cnt_r      <= {ADDR_W{1'b0}};
            gap_cnt_r      <= {GAP_W{1'b0}};
            wd_cnt_r       <= {WD_W{1'b0}};
            sensor_start_r <= 1'b0;
            buf_we_r       <= 1'b0;
            buf_addr_r     <= {(ADDR_W + 1){1'b0}};
            buf_wdata_r    <= 8'd0;
            frame_done_r   <= 1'b0;
            frame_idx_r    <= {FRAME_W{1'b0}};
            busy_r         <= 1'b0;
            timeout_err_r  <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            sensor_start_r <= (state_nx_s == CAPTURE);
            busy_r         <= (state_nx_s != IDLE);
            buf_we_r       <= accept_s;
            frame_done_r   <= frame_end_s;
            if (accept_s) begin
                buf_addr_r  <= {wr_bank_s, pix_cnt_r};
                buf_wdata_r <= ds_data;
            end
            if (frame_end_s || wd_expire_s) begin
                pix_cnt_r <= {ADDR_W{1'b0}};
            end else if (accept_s) begin
                pix_cnt_r <= pix_cnt_r + ADDR_W'(1);
            end
            // Watchdog restarts on every pixel and whenever capture is (re)entered.
            if ((state_r != CAPTURE) || ds_valid) begin
                wd_cnt_r <= {WD_W{1'b0}};
            end else begin
                wd_cnt_r <= wd_cnt_r + WD_W'(1);
            end
            if ((state_r == GAP) && !gap_end_s) begin
                gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end else begin
                gap_cnt_r <= {GAP_W{1'b0}};
            end
            if ((state_r == IDLE) && (state_nx_s != IDLE)) begin
                frame_idx_r <= {FRAME_W{1'b0}};
            end else if (frame_end_s && (frame_idx_r != {FRAME_W{1'b1}})) begin
                frame_idx_r <= frame_idx_r + FRAME_W'(1);
            end
            if (wd_expire_s) begin
                timeout_err_r <= 1'b1;
            end else if ((state_r == ERR) && !cfg_run) begin
                timeout_err_r <= 1'b0;
            end
        end
    end

    assign sensor_start = sensor_start_r;
    assign buf_we       = buf_we_r;
    assign buf_addr     = buf_addr_r;
    assign buf_wdata    = buf_wdata_r;
    assign rd_ready     = rd_ready_s;
    assign frame_done   = frame_done_r;
    assign frame_idx    = frame_idx_r;
    assign busy         = busy_r;
    assign timeout_err  = timeout_err_r;

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Sequences image capture for the LeNet-5 front end and replaces the ad-hoc start/stop/delay logic at the top level.
- Drives the pseudo-sensor start level and counts down-scaled pixels (32x32 = 1024 per frame).
- Writes each pixel into a ping-pong frame buffer and hands full banks to the downstream consumer with a ready/release handshake.
- Enforces an inter-frame gap, an optional frame limit and a stall watchdog.
- Sits between down_scale_PU output and the buffer/classifier core.

Parameters:
PIX_PER_FRAME, 1024, down-scaled pixels per frame
ADDR_W, 10, pixel address width; must satisfy 2^ADDR_W >= PIX_PER_FRAME
GAP_CYCLES, 100, idle cycles between end of one frame and the next start
TIMEOUT_CYCLES, 1048576, max cycles between ds_valid pulses during capture before error
FRAME_W, 8, width of frame limit and frame counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cfg_run  in  1  level enable; 1 = keep capturing
cfg_num_frames  in  FRAME_W  frames to capture per run; 0 = continuous
ds_valid  in  1  down-scaled pixel strobe
ds_data  in  8  down-scaled pixel
sensor_start  out  1  level start to pseudo-sensor
buf_we  out  1  buffer write enable
buf_addr  out  ADDR_W+1  {bank, pixel index}
buf_wdata  out  8  buffer write data
rd_ready  out  2  per-bank full flag
rd_release  in  2  per-bank release pulse from consumer
frame_done  out  1  one-cycle pulse on final pixel write of a frame
frame_idx  out  FRAME_W  frames completed this run
busy  out  1  state != IDLE
timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset values: all outputs 0, state IDLE, wr_bank=0, pix_cnt=0, gap_cnt=0, wd_cnt=0.
- States: IDLE, WAIT_BUF, CAPTURE, GAP, DONE, ERR.
- IDLE:
  - frame_idx cleared on the IDLE->active transition.
  - If cfg_run=1: go to CAPTURE when rd_ready[wr_bank]=0, else go to WAIT_BUF.
- WAIT_BUF:
  - Move to CAPTURE the cycle after rd_ready[wr_bank] reads 0.
  - If cfg_run=0, return to IDLE.
- CAPTURE:
  - sensor_start=1, registered, high from the first CAPTURE cycle.
  - Each ds_valid registers buf_we=1, buf_addr={wr_bank,pix_cnt}, buf_wdata=ds_data. Latency 1 cycle; back-to-back valids are supported.
  - pix_cnt increments per valid. On a valid with pix_cnt==PIX_PER_FRAME-1:
    - pix_cnt<=0 and rd_ready[wr_bank]<=1.
    - wr_bank toggles and frame_idx increments (saturating at max).
    - frame_done pulses aligned with the final buf_we.
    - sensor_start<=0; go to GAP with gap_cnt=0.
  - cfg_run falling mid-frame does not abort; the frame completes.
- Watchdog:
  - wd_cnt clears on every ds_valid and on entry to CAPTURE.
  - If wd_cnt reaches TIMEOUT_CYCLES-1 in CAPTURE: go to ERR, set timeout_err=1, sensor_start=0, pix_cnt=0.
  - The bank being written stays not-ready.
- GAP:
  - Counts GAP_CYCLES cycles. sensor_start stays 0; ds_valid is ignored.
  - At gap end:
    - If cfg_num_frames!=0 and frame_idx==cfg_num_frames, go to DONE.
    - Else if cfg_run=0, go to IDLE.
    - Else go to CAPTURE or WAIT_BUF per rd_ready[wr_bank].
- DONE: hold until cfg_run=0, then go to IDLE.
- ERR: hold until cfg_run=0, then go to IDLE and clear timeout_err.
- ds_valid outside CAPTURE: ignored, no write.
- rd_release[b]:
  - Clears rd_ready[b] in the next cycle.
  - A release of a bank that is not ready is ignored.
  - Release and set of the same bank in the same cycle: set wins.
  - Both bits may release simultaneously.
- Consumer ordering: banks fill alternately starting at bank 0 after reset. wr_bank is not reset by returning to IDLE.
- Reset mid-operation: everything returns to reset values next edge; rd_ready is cleared and buffer contents are invalid.

Decomposition:
- Package lenet_pkg holds:
  - the state enum (IDLE, WAIT_BUF, CAPTURE, GAP, DONE, ERR);
  - localparams IMG_DS_W=32 and IMG_DS_H=32, with PIX_PER_FRAME derived from them;
  - default GAP_CYCLES and TIMEOUT_CYCLES.
- One natural sub-module, pingpong_bank_tracker. It holds the rd_ready flags and the wr_bank toggle, and applies the set/release priority.
- The FSM, counters and watchdog stay in frame_sequencer.

Test Plan:
- Reset then cfg_run=1, cfg_num_frames=2, sensor model emits 1024 valids per frame, consumer releases immediately.
  - sensor_start rises 1 cycle after run.
  - Addresses 0..1023 in bank 0, then 1024..2047 in bank 1.
  - Two frame_done pulses, with exactly 100 cycles of sensor_start=0 between frames.
  - Ends in DONE with frame_idx=2.
- Continuous mode, consumer never releases.
  - After 2 frames rd_ready=2'b11 and state is WAIT_BUF.
  - rd_release=2'b01 pulse leads to CAPTURE into bank 0 the cycle after rd_ready[0] reads 0.
- ds_valid stream stalls after 500 pixels with TIMEOUT_CYCLES=64.
  - ERR and timeout_err=1 after 64 idle cycles; rd_ready unchanged.
  - cfg_run=0 then 1 clears the error and restarts at address 0.
- cfg_run dropped at pixel 300: capture completes to pixel 1023, frame_done pulses, GAP, then IDLE.
- Same-cycle set of bank 1 and rd_release=2'b10: rd_ready[1]=1 afterwards.
- Same-cycle release of both banks: rd_ready=2'b00.
- rst_n low at pixel 700: all outputs 0 next cycle; restart writes begin at bank 0, address 0.
